// File: rtl/seven_segment_demultiplexer.sv
// rtl/seven_segment_demultiplexer.sv - recovers hex digits from a multiplexed 4-digit seven-segment bus
module seven_segment_demultiplexer #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  select_in,
    input  logic [6:0]  segment_in,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        decode_error
);

    // The sample leaves the synchronizer one edge before it can first match prev_q,
    // so acceptance happens when the count reaches STABLE_CYCLES-2.
    localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {SYNC, EXP2, EXP1, EXP0} state_t;

    logic [3:0]  sel_meta_q, sel_sync_q;
    logic [6:0]  seg_meta_q, seg_sync_q;
    logic [10:0] prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  valid_q, valid_d;
    logic        err_q, err_d;
    logic        frame_done_q, frame_done_d;
    state_t      state_q, state_d;

    logic        match;
    logic        accept;
    logic        onecold;
    logic [1:0]  idx;
    logic        seg_legal;
    logic        seg_blank;
    logic [3:0]  nibble;

    assign match  = ({sel_sync_q, seg_sync_q} == prev_q);
    assign accept = match && (cnt_q == ACCEPT_CNT);

    always_comb begin
        cnt_d = 8'd0;
        if (match) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_meta_q <= 4'hF;
            sel_sync_q <= 4'hF;
            seg_meta_q <= 7'h00;
            seg_sync_q <= 7'h00;
            prev_q     <= {4'hF, 7'h00};
            cnt_q      <= 8'd0;
        end else begin
            sel_meta_q <= select_in;
            sel_sync_q <= sel_meta_q;
            seg_meta_q <= segment_in;
            seg_sync_q <= seg_meta_q;
            prev_q     <= {sel_sync_q, seg_sync_q};
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        onecold = 1'b1;
        idx     = 2'd0;
        case (sel_sync_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: onecold = 1'b0;
        endcase
    end

    always_comb begin
        seg_legal = 1'b1;
        seg_blank = 1'b0;
        nibble    = 4'h0;
        case (seg_sync_q)
            7'h3F: nibble = 4'h0;
            7'h06: nibble = 4'h1;
            7'h5B: nibble = 4'h2;
            7'h4F: nibble = 4'h3;
            7'h66: nibble = 4'h4;
            7'h6D: nibble = 4'h5;
            7'h7D: nibble = 4'h6;
            7'h07: nibble = 4'h7;
            7'h7F: nibble = 4'h8;
            7'h6F: nibble = 4'h9;
            7'h77: nibble = 4'hA;
            7'h7C: nibble = 4'hB;
            7'h39: nibble = 4'hC;
            7'h5E: nibble = 4'hD;
            7'h79: nibble = 4'hE;
            7'h71: nibble = 4'hF;
            7'h00: begin
                seg_legal = 1'b0;
                seg_blank = 1'b1;
            end
            default: seg_legal = 1'b0;
        endcase
    end

    // Digit storage ignores scan order; only frame_done depends on it.
    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        err_d    = err_q;
        if (accept && onecold) begin
            if (seg_legal) begin
                digits_d[{idx, 2'b00} +: 4] = nibble;
                valid_d[idx]                = 1'b1;
            end else begin
                valid_d[idx] = 1'b0;
                if (!seg_blank) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept && onecold) begin
            if (idx == 2'd3) begin
                state_d = EXP2;
            end else begin
                case (state_q)
                    EXP2:    state_d = (idx == 2'd2) ? EXP1 : SYNC;
                    EXP1:    state_d = (idx == 2'd1) ? EXP0 : SYNC;
                    default: state_d = SYNC;
                endcase
            end
        end
    end

    always_comb begin
        frame_done_d = accept && onecold && (state_q == EXP0) && (idx == 2'd0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digits_q     <= 16'h0000;
            valid_q      <= 4'h0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digits       = digits_q;
    assign digit_valid  = valid_q;
    assign frame_done   = frame_done_q;
    assign decode_error = err_q;

endmodule

// File: tb/tb_seven_segment_demultiplexer.sv
// tb/tb_seven_segment_demultiplexer.sv - directed self-checking bench for seven_segment_demultiplexer
module tb_seven_segment_demultiplexer;

    logic        clock;
    logic        reset_n;
    logic [3:0]  select_in;
    logic [6:0]  segment_in;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        decode_error;

    int checks;
    int errors;
    int fd_count;
    int fd_edge;
    int chg_edge;

    seven_segment_demultiplexer #(.STABLE_CYCLES(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .select_in    (select_in),
        .segment_in   (segment_in),
        .digits       (digits),
        .digit_valid  (digit_valid),
        .frame_done   (frame_done),
        .decode_error (decode_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one input pattern and hold it n edges, noting frame_done pulses and the first output change.
    task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
        logic [20:0] snap;
        @(negedge clock);
        select_in  = sel;
        segment_in = seg;
        snap       = {digits, digit_valid, decode_error};
        fd_count   = 0;
        fd_edge    = 0;
        chg_edge   = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            #1;
            if (frame_done) begin
                fd_count++;
                fd_edge = k;
            end
            if (chg_edge == 0 && {digits, digit_valid, decode_error} != snap) chg_edge = k;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        select_in  = 4'hF;
        segment_in = 7'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_valid", 32'(digit_valid), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        check("rst_err", 32'(decode_error), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        hold(4'hF, 7'h00, 10);
        check("idle_nochg", 32'(chg_edge), 32'd0);

        // clean scan 3,2,1,0
        hold(4'b0111, 7'h4F, 10);
        check("scan_d3_lat", 32'(chg_edge), 32'd6);
        hold(4'b1011, 7'h06, 10);
        hold(4'b1101, 7'h5B, 10);
        hold(4'b1110, 7'h3F, 10);
        check("scan_fd_cnt", 32'(fd_count), 32'd1);
        check("scan_fd_edge", 32'(fd_edge), 32'd6);
        check("scan_digits", 32'(digits), 32'h3120);
        check("scan_valid", 32'(digit_valid), 32'hF);
        check("scan_err", 32'(decode_error), 32'h0);

        hold(4'hF, 7'h00, 10);
        check("nosel_nochg", 32'(chg_edge), 32'd0);

        // glitch: too short to accept
        hold(4'b1011, 7'h7F, 3);
        check("glitch_nochg", 32'(chg_edge), 32'd0);
        hold(4'b1101, 7'h6F, 10);
        check("glitch_lat", 32'(chg_edge), 32'd6);
        check("glitch_digits", 32'(digits), 32'h3190);
        check("glitch_valid", 32'(digit_valid), 32'hF);

        // blank clears valid without error
        hold(4'b1110, 7'h00, 10);
        check("blank_valid", 32'(digit_valid), 32'hE);
        check("blank_digits", 32'(digits), 32'h3190);
        check("blank_err", 32'(decode_error), 32'h0);

        // illegal pattern is sticky
        hold(4'b1101, 7'h55, 10);
        check("illegal_err", 32'(decode_error), 32'h1);
        check("illegal_valid", 32'(digit_valid), 32'hC);
        check("illegal_digits", 32'(digits), 32'h3190);
        hold(4'b1101, 7'h5B, 10);
        check("sticky_err", 32'(decode_error), 32'h1);
        check("sticky_digits", 32'(digits), 32'h3120);
        check("sticky_valid", 32'(digit_valid), 32'hE);

        // out of order 3,1,0
        hold(4'b0111, 7'h66, 10);
        check("ooo_fd3", 32'(fd_count), 32'd0);
        hold(4'b1101, 7'h07, 10);
        check("ooo_fd1", 32'(fd_count), 32'd0);
        hold(4'b1110, 7'h7D, 10);
        check("ooo_fd0", 32'(fd_count), 32'd0);
        check("ooo_digits", 32'(digits), 32'h4176);
        check("ooo_valid", 32'(digit_valid), 32'hF);
        hold(4'b0011, 7'h06, 10);
        check("twolow_nochg", 32'(chg_edge), 32'd0);
        check("twolow_fd", 32'(fd_count), 32'd0);

        // reset during EXP1 with a partially stable digit-1 sample
        hold(4'b0111, 7'h4F, 10);
        hold(4'b1011, 7'h06, 10);
        hold(4'b1101, 7'h5B, 3);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_digits", 32'(digits), 32'h0);
        check("arst_valid", 32'(digit_valid), 32'h0);
        check("arst_err", 32'(decode_error), 32'h0);
        check("arst_fd", 32'(frame_done), 32'h0);
        select_in  = 4'hF;
        segment_in = 7'h00;
        @(negedge clock);
        reset_n = 1'b1;
        hold(4'b1101, 7'h5B, 10);
        check("post_rst_lat", 32'(chg_edge), 32'd6);
        hold(4'b0111, 7'h4F, 10);
        hold(4'b1011, 7'h06, 10);
        hold(4'b1101, 7'h5B, 10);
        hold(4'b1110, 7'h3F, 10);
        check("post_rst_fd", 32'(fd_count), 32'd1);
        check("post_rst_digits", 32'(digits), 32'h3120);
        check("post_rst_valid", 32'(digit_valid), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
